// File: rtl/alu_operand_fetch_if.sv
// Bundle of the instruction-in, operand-out and write-back signals of the operand-fetch stage.
// Both handshakes transfer on a rising edge where valid && ready; a producer holds its payload stable while valid && !ready.
interface alu_operand_fetch_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_rs1_idx;
  logic [IDX_W-1:0] in_rs2_idx;
  logic [IDX_W-1:0] in_rd_idx;
  logic             in_use_imm;
  logic [XLEN-1:0]  in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_rs1;
  logic [XLEN-1:0]  out_rs2;
  logic [IDX_W-1:0] out_rd_idx;
  logic             wb_en;
  logic [IDX_W-1:0] wb_idx;
  logic [XLEN-1:0]  wb_data;

  modport master (
    output in_valid, in_rs1_idx, in_rs2_idx, in_rd_idx, in_use_imm, in_imm,
    output out_ready, wb_en, wb_idx, wb_data,
    input  in_ready, out_valid, out_rs1, out_rs2, out_rd_idx
  );

  modport slave (
    input  in_valid, in_rs1_idx, in_rs2_idx, in_rd_idx, in_use_imm, in_imm,
    input  out_ready, wb_en, wb_idx, wb_data,
    output in_ready, out_valid, out_rs1, out_rs2, out_rd_idx
  );
endinterface

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage: 32-entry register file, busy scoreboard for RAW hazards,
// write-back bypass into the fetch, and one registered operand slot feeding the ALU.
module alu_operand_fetch #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_operand_fetch_if.slave   bus
);
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic             out_valid_q;
  logic [XLEN-1:0]  out_rs1_q, out_rs1_d;
  logic [XLEN-1:0]  out_rs2_q, out_rs2_d;
  logic [IDX_W-1:0] out_rd_idx_q;

  logic wb_hit1, wb_hit2, hazard, in_ready, accept, wb_write;

  assign wb_write = bus.wb_en && (bus.wb_idx != '0);
  assign wb_hit1  = bus.wb_en && (bus.wb_idx == bus.in_rs1_idx);
  assign wb_hit2  = bus.wb_en && (bus.wb_idx == bus.in_rs2_idx);

  // A write-back landing this cycle resolves the hazard on its register.
  assign hazard = (busy_q[bus.in_rs1_idx] && !wb_hit1) ||
                  (!bus.in_use_imm && busy_q[bus.in_rs2_idx] && !wb_hit2);

  assign in_ready = !rst && (!out_valid_q || bus.out_ready) && !(bus.in_valid && hazard);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    out_rs1_d = '0;
    if (bus.in_rs1_idx != '0) begin
      out_rs1_d = wb_hit1 ? bus.wb_data : regs_q[bus.in_rs1_idx];
    end
    out_rs2_d = '0;
    if (bus.in_use_imm) begin
      out_rs2_d = bus.in_imm;
    end else if (bus.in_rs2_idx != '0) begin
      out_rs2_d = wb_hit2 ? bus.wb_data : regs_q[bus.in_rs2_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q       <= '0;
      out_valid_q  <= 1'b0;
      out_rs1_q    <= '0;
      out_rs2_q    <= '0;
      out_rd_idx_q <= '0;
    end else begin
      if (wb_write) begin
        regs_q[bus.wb_idx] <= bus.wb_data;
        busy_q[bus.wb_idx] <= 1'b0;
      end
      // Issued after the clear so that a same-index set wins.
      if (accept) begin
        out_valid_q  <= 1'b1;
        out_rs1_q    <= out_rs1_d;
        out_rs2_q    <= out_rs2_d;
        out_rd_idx_q <= bus.in_rd_idx;
        if (bus.in_rd_idx != '0) busy_q[bus.in_rd_idx] <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_rs1    = out_rs1_q;
  assign bus.out_rs2    = out_rs2_q;
  assign bus.out_rd_idx = out_rd_idx_q;
endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed bench for alu_operand_fetch: reset, bypass, RAW stall, hold, x0 handling, reset mid-flight.
module tb_alu_operand_fetch;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu_operand_fetch_if #(.XLEN(32), .IDX_W(5)) bus ();

  alu_operand_fetch #(.XLEN(32), .NREGS(32), .IDX_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [4:0] rd);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".rs1"}, bus.out_rs1, r1);
    check({tag, ".rs2"}, bus.out_rs2, r2);
    check({tag, ".rd"}, 32'(bus.out_rd_idx), 32'(rd));
  endtask

  task automatic check_ready(input string tag, input logic exp);
    #1;
    check(tag, 32'(bus.in_ready), 32'(exp));
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.in_rs1_idx = '0;
    bus.in_rs2_idx = '0;
    bus.in_rd_idx  = '0;
    bus.in_use_imm = 1'b0;
    bus.in_imm     = '0;
    bus.out_ready  = 1'b1;
    bus.wb_en      = 1'b0;
    bus.wb_idx     = '0;
    bus.wb_data    = '0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic use_imm, input logic [31:0] imm);
    bus.in_valid   = 1'b1;
    bus.in_rs1_idx = rs1;
    bus.in_rs2_idx = rs2;
    bus.in_rd_idx  = rd;
    bus.in_use_imm = use_imm;
    bus.in_imm     = imm;
  endtask

  task automatic wb(input logic [4:0] idx, input logic [31:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_idx  = idx;
    bus.wb_data = data;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle();
    tick();
    tick();
    issue(5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    check_ready("rst_in_ready", 1'b0);
    check_out("reset", 1'b0, 32'd0, 32'd0, 5'd0);
    idle();
    rst = 1'b0;

    // Register writes then a plain register-register issue
    wb(5'd1, 32'd1431655765);
    tick();
    wb(5'd2, 32'd10);
    tick();
    idle();
    issue(5'd1, 5'd2, 5'd3, 1'b0, 32'd0);
    check_ready("rr_ready", 1'b1);
    tick();
    idle();
    check_out("rr", 1'b1, 32'd1431655765, 32'd10, 5'd3);

    // Immediate operand with write-back bypass on rs1
    issue(5'd1, 5'd0, 5'd0, 1'b1, 32'd72);
    wb(5'd1, 32'd4294967295);
    check_ready("byp_ready", 1'b1);
    tick();
    idle();
    check_out("bypass", 1'b1, 32'hFFFF_FFFF, 32'd72, 5'd0);

    // RAW stall on x5 until its write-back arrives
    issue(5'd0, 5'd0, 5'd5, 1'b0, 32'd0);
    tick();
    check_out("raw_prod", 1'b1, 32'd0, 32'd0, 5'd5);
    issue(5'd5, 5'd0, 5'd6, 1'b0, 32'd0);
    check_ready("raw_stall0", 1'b0);
    tick();
    check_out("raw_drain", 1'b0, 32'd0, 32'd0, 5'd5);
    check_ready("raw_stall1", 1'b0);
    tick();
    wb(5'd5, 32'd7);
    check_ready("raw_wb_ready", 1'b1);
    tick();
    idle();
    check_out("raw_cons", 1'b1, 32'd7, 32'd0, 5'd6);

    // Hold under back-pressure; later write-backs must not disturb held operands
    issue(5'd1, 5'd2, 5'd7, 1'b0, 32'd0);
    tick();
    check_out("hold_first", 1'b1, 32'hFFFF_FFFF, 32'd10, 5'd7);
    bus.out_ready = 1'b0;
    issue(5'd1, 5'd0, 5'd0, 1'b0, 32'd0);
    wb(5'd1, 32'hAAAA_0001);
    check_ready("hold_ready0", 1'b0);
    tick();
    check_out("hold0", 1'b1, 32'hFFFF_FFFF, 32'd10, 5'd7);
    wb(5'd1, 32'hBBBB_0002);
    check_ready("hold_ready1", 1'b0);
    tick();
    check_out("hold1", 1'b1, 32'hFFFF_FFFF, 32'd10, 5'd7);
    wb(5'd1, 32'h1234_5678);
    check_ready("hold_ready2", 1'b0);
    tick();
    check_out("hold2", 1'b1, 32'hFFFF_FFFF, 32'd10, 5'd7);
    bus.wb_en     = 1'b0;
    bus.out_ready = 1'b1;
    check_ready("hold_release", 1'b1);
    tick();
    check_out("hold_next", 1'b1, 32'h1234_5678, 32'd0, 5'd0);
    idle();
    tick();
    check_out("drain_keep", 1'b0, 32'h1234_5678, 32'd0, 5'd0);

    // x0 is never written, never busy, and never bypassed
    wb(5'd0, 32'd123);
    tick();
    idle();
    issue(5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    check_ready("x0_ready0", 1'b1);
    tick();
    check_out("x0_read", 1'b1, 32'd0, 32'd0, 5'd0);
    issue(5'd0, 5'd0, 5'd9, 1'b0, 32'd0);
    wb(5'd0, 32'd99);
    check_ready("x0_ready1", 1'b1);
    tick();
    idle();
    check_out("x0_bypass", 1'b1, 32'd0, 32'd0, 5'd9);

    // Reset while holding a valid result with x4 busy
    wb(5'd4, 32'd55);
    tick();
    idle();
    bus.out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd4, 1'b0, 32'd0);
    tick();
    idle();
    bus.out_ready = 1'b0;
    check_out("pre_rst", 1'b1, 32'd0, 32'd0, 5'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check_out("post_rst", 1'b0, 32'd0, 32'd0, 5'd0);
    issue(5'd4, 5'd4, 5'd0, 1'b0, 32'd0);
    check_ready("rst_x4_ready", 1'b1);
    tick();
    issue(5'd1, 5'd2, 5'd0, 1'b0, 32'd0);
    check_out("rst_x4", 1'b1, 32'd0, 32'd0, 5'd0);
    check_ready("rst_b2b_ready", 1'b1);
    tick();
    idle();
    check_out("rst_x1x2", 1'b1, 32'd0, 32'd0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
